// File: rtl/i2c_bus_arbiter_if.sv
// i2c_bus_arbiter_if: requester-side and master-engine-side signals of the I2C bus arbiter.
interface i2c_bus_arbiter_if #(parameter int NREQ = 4);
    logic [NREQ-1:0]   req;
    logic [7*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_rw;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic              busy;
    logic              mst_start;
    logic [6:0]        mst_addr;
    logic              mst_rw;
    logic              mst_done;
    logic              mst_nack;
    modport master (input req, req_addr, req_rw, mst_done, mst_nack,
                    output grant, done, err, busy, mst_start, mst_addr, mst_rw);
    modport slave  (output req, req_addr, req_rw, mst_done, mst_nack,
                    input grant, done, err, busy, mst_start, mst_addr, mst_rw);
endinterface

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sequencer sharing one i2c_master among NREQ requesters.
// Define I2C_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYC cycles with an err pulse.
module i2c_bus_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 2000
) (
    input logic             clk_200kHz,
    input logic             reset,
    i2c_bus_arbiter_if.master bus
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;
    state_t state, state_n;
    logic [PW-1:0] ptr, ptr_n, owner, owner_n, pick;
    logic [PW:0] sum;
    logic [2*NREQ-1:0] rot;
    logic found, finish, fail, start_n, rw_n;
    logic [NREQ-1:0] grant_n, done_n, err_n;
    logic [6:0] addr_n;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    logic [CW-1:0] cnt, cnt_n;
`endif
    // Rotate the request vector so bit 0 is the requester at ptr; first hit wins.
    always_comb begin
        rot = {bus.req, bus.req} >> ptr;
        pick = '0;
        found = 1'b0;
        sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                sum = {1'b0, ptr} + (PW+1)'(k);
                pick = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        owner_n = owner;
        grant_n = bus.grant;
        done_n = '0;
        err_n = '0;
        start_n = 1'b0;
        addr_n = bus.mst_addr;
        rw_n = bus.mst_rw;
        finish = bus.mst_done;
        fail = bus.mst_nack;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_n = cnt;
`endif
        case (state)
            IDLE: if (found) begin
                state_n = START;
                owner_n = pick;
                grant_n = NREQ'(1) << pick;
                addr_n = bus.req_addr[7*pick +: 7];
                rw_n = bus.req_rw[pick];
                start_n = 1'b1;
            end
            START: begin
                state_n = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                cnt_n = '0;
`endif
            end
            WAIT: begin
`ifdef I2C_ARB_TIMEOUT_EN
                // A completion landing on the terminal count takes precedence over the abort.
                finish = bus.mst_done || cnt == CW'(TIMEOUT_CYC - 1);
                fail = !bus.mst_done || bus.mst_nack;
                cnt_n = cnt + 1'b1;
`endif
                if (finish) begin
                    state_n = HOLD;
                    grant_n = '0;
                    done_n[owner] = !fail;
                    err_n[owner] = fail;
                    ptr_n = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_200kHz or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr <= '0;
            owner <= '0;
            bus.grant <= '0;
            bus.done <= '0;
            bus.err <= '0;
            bus.busy <= 1'b0;
            bus.mst_start <= 1'b0;
            bus.mst_addr <= '0;
            bus.mst_rw <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt <= '0;
`endif
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            owner <= owner_n;
            bus.grant <= grant_n;
            bus.done <= done_n;
            bus.err <= err_n;
            bus.busy <= state_n != IDLE;
            bus.mst_start <= start_n;
            bus.mst_addr <= addr_n;
            bus.mst_rw <= rw_n;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt <= cnt_n;
`endif
        end
    end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: vector table, corner-case sequences and a randomized
// transaction-level round-robin model for i2c_bus_arbiter (NREQ=4).
module tb_i2c_bus_arbiter;
    localparam int N = 4;
    typedef struct {
        logic [3:0] req;
        logic       nack;
        logic [3:0] grant;
        logic [6:0] addr;
        logic       rw;
    } vec_t;
    logic clk_200kHz = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    vec_t vecs[8];
    i2c_bus_arbiter_if #(.NREQ(N)) bus();
    i2c_bus_arbiter #(.NREQ(N), .TIMEOUT_CYC(20)) dut (
        .clk_200kHz(clk_200kHz),
        .reset(reset),
        .bus(bus.master)
    );
    always #5 clk_200kHz = ~clk_200kHz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_200kHz);
        #1;
    endtask

    // Called in WAIT: pulse mst_done, check the result pulse, then HOLD -> IDLE.
    task automatic finish_txn(input logic nack, input logic [3:0] g, input string tag);
        bus.mst_done = 1'b1;
        bus.mst_nack = nack;
        tick();
        bus.mst_done = 1'b0;
        bus.mst_nack = 1'b0;
        check({tag, " done"}, bus.done, nack ? 4'b0 : g);
        check({tag, " err"}, bus.err, nack ? g : 4'b0);
        check({tag, " grant_clr"}, bus.grant, 0);
        check({tag, " busy_hold"}, bus.busy, 1);
        bus.req = '0;
        tick();
        check({tag, " busy_idle"}, bus.busy, 0);
        check({tag, " pulse_1cyc"}, {bus.done, bus.err}, 0);
    endtask

    task automatic run_txn(input logic [3:0] r, input logic nack, input int gap, input logic [3:0] g,
                           input logic [6:0] a, input logic rw, input string tag);
        bus.req = r;
        tick();
        check({tag, " grant"}, bus.grant, g);
        check({tag, " start"}, bus.mst_start, 1);
        check({tag, " addr"}, bus.mst_addr, a);
        check({tag, " rw"}, bus.mst_rw, rw);
        tick();
        check({tag, " start_drop"}, bus.mst_start, 0);
        if (gap > 0) tick(gap);
        check({tag, " addr_stable"}, bus.mst_addr, a);
        finish_txn(nack, g, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] a_vec;
        logic [3:0] r, rw_vec, g;
        logic [6:0] ea;
        int w, m_ptr, n;
        logic nack;
        vecs[0] = '{4'b0101, 1'b1, 4'b0100, 7'h22, 1'b0};
        vecs[1] = '{4'b0011, 1'b0, 4'b0001, 7'h4B, 1'b1};
        vecs[2] = '{4'b0011, 1'b0, 4'b0010, 7'h11, 1'b0};
        vecs[3] = '{4'b1111, 1'b1, 4'b0100, 7'h22, 1'b0};
        vecs[4] = '{4'b1001, 1'b0, 4'b1000, 7'h33, 1'b1};
        vecs[5] = '{4'b1000, 1'b0, 4'b1000, 7'h33, 1'b1};
        vecs[6] = '{4'b1010, 1'b0, 4'b0010, 7'h11, 1'b0};
        vecs[7] = '{4'b0001, 1'b1, 4'b0001, 7'h4B, 1'b1};
        bus.req = '0;
        bus.req_addr = {7'h33, 7'h22, 7'h11, 7'h4B};
        bus.req_rw = 4'b1001;
        bus.mst_done = 1'b0;
        bus.mst_nack = 1'b0;
        #12;
        check("rst grant", bus.grant, 0);
        check("rst done", bus.done, 0);
        check("rst err", bus.err, 0);
        check("rst busy", bus.busy, 0);
        check("rst start", bus.mst_start, 0);
        check("rst addr", bus.mst_addr, 0);
        check("rst rw", bus.mst_rw, 0);
        reset = 1'b1;
        tick();
        run_txn(4'b0001, 1'b0, 48, 4'b0001, 7'h4B, 1'b1, "single");
        for (int i = 0; i < 8; i++)
            run_txn(vecs[i].req, vecs[i].nack, i % 3, vecs[i].grant, vecs[i].addr, vecs[i].rw,
                    $sformatf("vec%0d", i));
        // Lone requester held high: served again after HOLD and one IDLE cycle.
        bus.req = 4'b0001;
        tick();
        tick();
        bus.mst_done = 1'b1;
        tick();
        bus.mst_done = 1'b0;
        check("b2b done", bus.done, 4'b0001);
        tick();
        check("b2b idle_busy", bus.busy, 0);
        check("b2b idle_start", bus.mst_start, 0);
        tick();
        check("b2b restart", bus.mst_start, 1);
        check("b2b regrant", bus.grant, 4'b0001);
        tick(6);
        bus.req = '0;
        tick(5);
        check("withdraw grant", bus.grant, 4'b0001);
        check("withdraw busy", bus.busy, 1);
        finish_txn(1'b0, 4'b0001, "withdraw");
        // Two requesters held high alternate.
        bus.req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            g = (i % 2 == 0) ? 4'b0010 : 4'b0001;
            tick();
            check($sformatf("fair%0d grant", i), bus.grant, g);
            tick();
            bus.mst_done = 1'b1;
            tick();
            bus.mst_done = 1'b0;
            check($sformatf("fair%0d done", i), bus.done, g);
            tick();
        end
        bus.req = '0;
        bus.mst_done = 1'b1;
        tick();
        bus.mst_done = 1'b0;
        check("idle_done busy", bus.busy, 0);
        check("idle_done pulses", {bus.done, bus.err}, 0);
        bus.req = 4'b1000;
        tick();
        check("startdone grant", bus.grant, 4'b1000);
        bus.mst_done = 1'b1;
        bus.mst_nack = 1'b1;
        tick();
        bus.mst_done = 1'b0;
        bus.mst_nack = 1'b0;
        check("startdone ignored", {bus.done, bus.err}, 0);
        tick();
        check("startdone still_wait", bus.grant, 4'b1000);
        finish_txn(1'b0, 4'b1000, "startdone");
        bus.req = 4'b0100;
        tick();
        tick();
`ifdef I2C_ARB_TIMEOUT_EN
        tick(19);
        check("to before err", bus.err, 0);
        check("to before grant", bus.grant, 4'b0100);
        tick();
        check("to err", bus.err, 4'b0100);
        check("to grant", bus.grant, 0);
        check("to done", bus.done, 0);
        bus.req = '0;
        tick();
        check("to idle", bus.busy, 0);
`else
        tick(1000);
        check("noto busy", bus.busy, 1);
        check("noto grant", bus.grant, 4'b0100);
        check("noto err", bus.err, 0);
        finish_txn(1'b0, 4'b0100, "noto");
`endif
        bus.req = 4'b1100;
        tick();
        check("arst pre grant", bus.grant, 4'b1000);
        tick(4);
        #3 reset = 1'b0;
        #1;
        check("arst grant", bus.grant, 0);
        check("arst busy", bus.busy, 0);
        check("arst start", bus.mst_start, 0);
        check("arst addr", bus.mst_addr, 0);
        #2 reset = 1'b1;
        tick();
        check("arst post grant", bus.grant, 4'b0100);
        check("arst post start", bus.mst_start, 1);
        tick();
        finish_txn(1'b0, 4'b0100, "arst");
        // Randomized transactions against a round-robin reference.
        m_ptr = 3;
        for (int t = 0; t < 60; t++) begin
            r = 4'($urandom_range(1, 15));
            a_vec = 28'($urandom);
            rw_vec = 4'($urandom);
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            g = 4'(1 << w);
            ea = a_vec[7*w +: 7];
            bus.req = r;
            bus.req_addr = a_vec;
            bus.req_rw = rw_vec;
            tick();
            check("rand grant", bus.grant, g);
            check("rand addr", bus.mst_addr, ea);
            check("rand rw", bus.mst_rw, rw_vec[w]);
            check("rand start", bus.mst_start, 1);
            tick();
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) begin
                bus.req = 4'($urandom);
                bus.req_addr = 28'($urandom);
                bus.req_rw = 4'($urandom);
                tick();
            end
            check("rand hold_grant", bus.grant, g);
            check("rand hold_addr", bus.mst_addr, ea);
            check("rand hold_rw", bus.mst_rw, rw_vec[w]);
            nack = 1'($urandom);
            finish_txn(nack, g, "rand");
            m_ptr = (w + 1) % N;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one i2c_master engine among NREQ requesters, e.g. the temperature poller, a config writer and a debug port.
- Sits between the requesters and the master in the 200 kHz clock domain.
- Latches the winner's target address and direction, fires one start pulse, waits for completion, then returns a done or err pulse to that requester.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- TIMEOUT_CYC, 2000, cycles allowed in WAIT before abort (10 ms at 200 kHz); used only with the optional feature.

Ports:
- clk_200kHz  in  1  block clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester transaction request; level, held until done/err.
- req_addr  in  7*NREQ  packed 7-bit I2C slave addresses; requester i occupies bits [7i+6:7i].
- req_rw  in  NREQ  per-requester direction; 1 = read.
- grant  out  NREQ  one-hot owner of the master; all zero when idle.
- done  out  NREQ  1-cycle pulse on successful completion.
- err  out  NREQ  1-cycle pulse on NACK or timeout.
- busy  out  1  high whenever state is not IDLE.
- mst_start  out  1  1-cycle start strobe to the master.
- mst_addr  out  7  latched slave address to the master.
- mst_rw  out  1  latched direction to the master.
- mst_done  in  1  master completion pulse.
- mst_nack  in  1  master NACK flag; valid in the cycle mst_done is high.

Behaviour:
- Reset (reset=0, asynchronous): grant=0, done=0, err=0, busy=0, mst_start=0, mst_addr=0, mst_rw=0, state=IDLE, rotation pointer ptr=0. All outputs are registered.
- States: IDLE -> START -> WAIT -> HOLD -> IDLE.
- IDLE:
  - If any req bit is high at edge N, select the first set bit scanning ptr, ptr+1, ... modulo NREQ.
  - At edge N+1: grant[i]=1, mst_addr=req_addr[i], mst_rw=req_rw[i], mst_start=1, state=START.
  - With no req, remain in IDLE.
- START: lasts exactly one cycle; mst_start drops; state=WAIT. mst_done seen in START is ignored.
- WAIT:
  - On mst_done=1, register the result at the next edge:
    - mst_nack=0 -> done[i] pulses for 1 cycle.
    - mst_nack=1 -> err[i] pulses for 1 cycle.
  - At the same edge: grant clears, ptr = (i+1) mod NREQ, state=HOLD.
- HOLD: one idle cycle to guarantee bus-free spacing; busy stays high; then IDLE.
- Stability: mst_addr and mst_rw stay stable from START through HOLD; they retain their last value in IDLE.
- req deasserted during START/WAIT: ignored; the transaction completes and done/err still pulses.
- Owner re-requests immediately: it has lowest priority next round (ptr moved past it), so fairness is guaranteed. With one active requester, back-to-back service occurs with 2 idle cycles (HOLD, IDLE) between transactions.
- req changes during START/WAIT/HOLD: no effect on grant.
- mst_done in IDLE or HOLD: ignored.
- Pointer: ptr width = $clog2(NREQ); NREQ-1 wraps to 0.
- Minimum latency: req high -> mst_start = 1 cycle; mst_done -> done/err pulse = 1 cycle.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC-1 with no mst_done: err[i] pulses, grant clears, ptr advances, state=HOLD.
  - If mst_done arrives in the same cycle as the terminal count, mst_done wins (done or NACK err as normal).
- When undefined: no counter is synthesised, TIMEOUT_CYC is unused, and WAIT persists until mst_done.

Test Plan:
- Single read: req=0001, req_addr[6:0]=0x4B, rw=1 -> next cycle grant=0001, mst_addr=0x4B, mst_rw=1, mst_start pulses once; mst_done after 50 cycles -> done=0001 for 1 cycle, grant=0000, busy low 2 cycles later.
- Fairness: req=0101 from reset -> requester 0 served first, then 2. Then req=0011 with ptr=3 -> requester 0 served, then 1. Requester held high -> never served twice in a row while others wait.
- NACK: mst_done=1 with mst_nack=1 for requester 2 -> err=0100 1-cycle pulse, done stays 0000.
- Withdrawal: req0 dropped 5 cycles into WAIT -> transaction continues; done[0] pulses on mst_done.
- Async reset mid-WAIT: reset=0 between clock edges -> grant, busy, mst_start, mst_addr immediately 0; after release, first grant goes to lowest-index active requester.
- Timeout (macro defined, TIMEOUT_CYC=20): no mst_done -> err[i] pulses 20 cycles after WAIT entry, then HOLD, IDLE. Macro undefined: still in WAIT after 1000 cycles.
